dmem_bus_bridge: RTL and testbench

//  Sits between the CPU data port (memory stage) and a wait-stated data SRAM/bus slave.

---
 rtl/cpu_pkg.sv | 12 +
 rtl/dmem_watchdog.sv | 30 +++
 rtl/dmem_bus_bridge.sv | 118 +++++++++++
 tb/tb_dmem_bus_bridge.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the data-memory bridge: FSM states and the full-word byte mask.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/dmem_watchdog.sv
// Cycle counter bounding how long one bus access may stay outstanding.
module dmem_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Expiry is checked before increment, so the counter never exceeds TIMEOUT.
  assign o_expire = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/dmem_bus_bridge.sv
// Memory-stage data port to wait-stated slave: req/ack handshake, pipeline stall,
// raw read word return and watchdog abort with a one-cycle error pulse.
module dmem_bus_bridge
  import cpu_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  input  logic [3:0]        cpu_be,
  input  logic              cpu_we,
  input  logic              cpu_re,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              bus_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata
);

  state_t            r_state;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-3:0] r_mem_addr;
  logic [3:0]        r_mem_be;
  logic [31:0]       r_mem_wdata;
  logic [31:0]       r_cpu_rdata;
  logic              r_bus_err;

  logic w_store;
  logic w_access;
  logic w_busy;
  logic w_expire;
  logic w_wd_clear;
  logic w_unused;

  // A store with no lanes enabled is a no-op; a load alongside it still goes out.
  assign w_store  = cpu_we && (cpu_be != 4'h0);
  assign w_access = cpu_re || w_store;
  assign w_busy   = (r_state == ST_BUSY);
  assign w_wd_clear = !w_busy || mem_ack || w_expire;
  assign w_unused = ^cpu_addr[1:0];

  dmem_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_wd_clear),
    .i_enable(w_busy),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 4'h0;
      r_mem_wdata <= 32'h0;
      r_cpu_rdata <= 32'h0;
      r_bus_err   <= 1'b0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_access) begin
            r_mem_addr  <= cpu_addr[ADDR_W-1:2];
            r_mem_be    <= w_store ? cpu_be : BE_WORD;
            r_mem_wdata <= cpu_wdata;
            r_mem_we    <= w_store;
            r_mem_req   <= 1'b1;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // An ack on the expiry cycle takes priority over the abort.
          if (mem_ack) begin
            if (!r_mem_we) begin
              r_cpu_rdata <= mem_rdata;
            end
            r_mem_req <= 1'b0;
            r_state   <= ST_DONE;
          end else if (w_expire) begin
            r_cpu_rdata <= 32'h0;
            r_bus_err   <= 1'b1;
            r_mem_req   <= 1'b0;
            r_state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cpu_stall = w_busy || ((r_state == ST_IDLE) && w_access);
  assign cpu_rdata = r_cpu_rdata;
  assign bus_err   = r_bus_err;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_be    = r_mem_be;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_dmem_bus_bridge.sv
// Scoreboard bench for dmem_bus_bridge: driver pushes expected outcomes, monitor checks them.
module tb_dmem_bus_bridge;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 4;

  logic              clk;
  logic              rst_n;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [3:0]        cpu_be;
  logic              cpu_we;
  logic              cpu_re;
  logic [31:0]       cpu_rdata;
  logic              cpu_stall;
  logic              bus_err;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  dmem_bus_bridge #(
    .ADDR_W (ADDR_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_be   (cpu_be),
    .cpu_we   (cpu_we),
    .cpu_re   (cpu_re),
    .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall),
    .bus_err  (bus_err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_be   (mem_be),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-3:0] addr;
    logic [3:0]        be;
    logic              we;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              err;
    int                stall;
  } exp_t;

  exp_t        sb_q[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model_rdata = 32'h0;
  int          slave_delay = 0;
  logic [31:0] slave_data = 32'h0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Slave: acks in BUSY cycle slave_delay+1; throws stray acks when no request is pending.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req) begin
        cnt++;
        if (cnt == slave_delay + 1) begin
          mem_ack = 1'b1;
          mem_rdata = slave_data;
        end
      end else begin
        cnt = 0;
        if ($urandom_range(0, 3) == 0) begin
          mem_ack = 1'b1;
          mem_rdata = $urandom;
        end
      end
    end
  end

  // Monitor: bus fields while requesting, completion on the falling edge of stall.
  initial begin
    int run;
    bit prev;
    exp_t e;
    run = 0;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_en || !rst_n) begin
        run = 0;
        prev = 1'b0;
      end else begin
        if (mem_req) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_req: got mem_req=1, required no request");
          end else begin
            check("mem_addr", 32'(mem_addr), 32'(sb_q[0].addr));
            check("mem_be", 32'(mem_be), 32'(sb_q[0].be));
            check("mem_we", 32'(mem_we), 32'(sb_q[0].we));
            if (sb_q[0].we) check("mem_wdata", mem_wdata, sb_q[0].wdata);
          end
        end
        if (cpu_stall) begin
          run++;
        end else if (prev) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got completion, required none");
          end else begin
            e = sb_q.pop_front();
            check("stall_cycles", 32'(run), 32'(e.stall));
            check("cpu_rdata", cpu_rdata, e.rdata);
            check("bus_err", 32'(bus_err), 32'(e.err));
            check("done_req", 32'(mem_req), 32'h0);
          end
          run = 0;
        end else begin
          check("bus_err_idle", 32'(bus_err), 32'h0);
        end
        prev = cpu_stall;
      end
    end
  end

  task automatic txn(input logic re, input logic we, input logic [3:0] be,
                     input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                     input int d, input logic [31:0] data);
    exp_t e;
    bit   store;
    bit   access;
    bit   acked;
    int   busy;
    int   guard;
    @(posedge clk);
    #1;
    cpu_re = re;
    cpu_we = we;
    cpu_be = be;
    cpu_addr = addr;
    cpu_wdata = wdata;
    slave_delay = d;
    slave_data = data;
    store = we && (be != 4'h0);
    access = re || store;
    if (!access) begin
      @(negedge clk);
      check("noop_stall", 32'(cpu_stall), 32'h0);
      check("noop_req", 32'(mem_req), 32'h0);
      return;
    end
    acked = (d + 1 <= TIMEOUT);
    busy = acked ? d + 1 : TIMEOUT;
    if (!acked) model_rdata = 32'h0;
    else if (!store) model_rdata = data;
    e.addr = addr[ADDR_W-1:2];
    e.be = store ? be : 4'hF;
    e.we = store;
    e.wdata = wdata;
    e.rdata = model_rdata;
    e.err = !acked;
    e.stall = 1 + busy;
    sb_q.push_back(e);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cpu_stall && guard < 40);
    if (cpu_stall) begin
      checks++;
      errors++;
      $display("FAIL txn_hang: got stall after %0d cycles, required release", guard);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cpu_re = 1'b0;
      cpu_we = 1'b0;
    end
  endtask

  initial begin
    logic              r_re;
    logic              r_we;
    logic [3:0]        r_be;
    logic [ADDR_W-1:0] r_addr;
    int                r_d;
    rst_n = 1'b0;
    cpu_addr = '0;
    cpu_wdata = 32'h0;
    cpu_be = 4'h0;
    cpu_we = 1'b0;
    cpu_re = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'h0);
    check("rst_mem_we", 32'(mem_we), 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    check("rst_mem_addr", 32'(mem_addr), 32'h0);
    check("rst_mem_be", 32'(mem_be), 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_stall", 32'(cpu_stall), 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    txn(1'b1, 1'b0, 4'h0, 10'h04C, 32'h0, 2, 32'hDEADBEEF);
    txn(1'b0, 1'b1, 4'b0100, 10'h120, 32'h00AB0000, 1, 32'h12345678);
    txn(1'b1, 1'b0, 4'h3, 10'h200, 32'h0, 0, 32'hA5A5_0001);
    txn(1'b1, 1'b0, 4'h0, 10'h204, 32'h0, 0, 32'hA5A5_0002);
    txn(1'b1, 1'b0, 4'hF, 10'h3FC, 32'h0, 99, 32'hBAD0_BAD0);
    txn(1'b0, 1'b1, 4'h0, 10'h010, 32'hFFFF_FFFF, 0, 32'h1111_1111);
    txn(1'b1, 1'b0, 4'hF, 10'h088, 32'h0, TIMEOUT - 1, 32'hCAFEF00D);
    txn(1'b1, 1'b1, 4'b0011, 10'h0F0, 32'h0000_BEEF, 0, 32'h7777_7777);
    idle(2);

    mon_en = 1'b0;
    @(posedge clk);
    #1;
    cpu_re = 1'b1;
    cpu_we = 1'b0;
    cpu_be = 4'hF;
    cpu_addr = 10'h3F0;
    slave_delay = 99;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", 32'(mem_req), 32'h0);
    check("rst_mid_rdata", cpu_rdata, 32'h0);
    check("rst_mid_be", 32'(mem_be), 32'h0);
    model_rdata = 32'h0;
    cpu_re = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_req", 32'(mem_req), 32'h0);
      check("post_rst_stall", 32'(cpu_stall), 32'h0);
      check("post_rst_err", 32'(bus_err), 32'h0);
    end
    mon_en = 1'b1;

    for (int i = 0; i < 200; i++) begin
      r_re = 1'($urandom_range(0, 1));
      r_we = 1'($urandom_range(0, 1));
      r_be = 4'($urandom);
      r_addr = ADDR_W'($urandom);
      r_d = $urandom_range(0, 5);
      txn(r_re, r_we, r_be, r_addr, $urandom, r_d, $urandom);
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 2));
    end
    idle(3);
    @(negedge clk);
    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL sb_leftover: got %0d pending, required 0", sb_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
